pipelined_adder: RTL

Parametrised, pipelined successor to the single-bit full adder. Adds or subtracts two WIDTH-bit operands and splits the carry chain into STAGES register stages. Uses valid/ready handshakes on input and output, so it can sit between streaming producers and consumers in datapath blocks. Reports carry-out and signed overflow with each result.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 87 ++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bundle for pipelined_adder: operand beats flow in
// on in_valid/in_ready, results flow out on out_valid/out_ready.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Add/subtract unit whose carry chain is cut into STAGES register stages of
// CHUNK bits each, with a single global advance enable driving every stage.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];
  logic             r_ovf;

  logic [WIDTH-1:0] w_aIn      [STAGES];
  logic [WIDTH-1:0] w_bIn      [STAGES];
  logic [WIDTH-1:0] w_sumIn    [STAGES];
  logic             w_cIn      [STAGES];
  logic [CHUNK:0]   w_chunkSum [STAGES];
  logic [WIDTH-1:0] w_sumNext  [STAGES];
  logic             w_adv;
  logic             w_ovfNext;

  assign w_adv = !r_valid[LAST] || bus.out_ready;

  // Stage 0 folds subtraction into an inverted b plus a forced carry-in;
  // later stages continue from the previous stage's registered carry.
  always_comb begin
    w_aIn[0]   = bus.a;
    w_bIn[0]   = bus.op_sub ? ~bus.b : bus.b;
    w_cIn[0]   = bus.op_sub | bus.cin;
    w_sumIn[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_aIn[k]   = r_a[k-1];
      w_bIn[k]   = r_b[k-1];
      w_cIn[k]   = r_carry[k-1];
      w_sumIn[k] = r_sum[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_chunkSum[k] = {1'b0, w_aIn[k][k*CHUNK +: CHUNK]}
                    + {1'b0, w_bIn[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, w_cIn[k]};
      w_sumNext[k] = w_sumIn[k];
      w_sumNext[k][k*CHUNK +: CHUNK] = w_chunkSum[k][CHUNK-1:0];
    end
  end

  assign w_ovfNext = (w_aIn[LAST][WIDTH-1] == w_bIn[LAST][WIDTH-1]) &&
                     (w_sumNext[LAST][WIDTH-1] != w_aIn[LAST][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_valid[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]     <= w_aIn[k];
        r_b[k]     <= w_bIn[k];
        r_sum[k]   <= w_sumNext[k];
        r_carry[k] <= w_chunkSum[k][CHUNK];
      end
      r_ovf <= w_ovfNext;
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_valid[LAST];
  assign bus.sum       = r_sum[LAST];
  assign bus.cout      = r_carry[LAST];
  assign bus.ovf       = r_ovf;
endmodule
